// File: rtl/serial_to_parallel_if.sv
// rtl/serial_to_parallel_if.sv - serial input / parallel output handshake bundle
//
// Signals:
//   serial_valid    serial_data carries a valid bit this cycle
//   serial_data     serial bit, LSB of the word first
//   parallel_ready  consumer accepts parallel_data this cycle
//   parallel_valid  parallel_data holds a complete, unconsumed word
//   parallel_data   assembled word, bit i = i-th accepted serial bit
//   busy            partial word in progress
//   overrun         one-cycle pulse: a completed word was dropped
// Modports:
//   master  producer/consumer side (drives serial_* and parallel_ready)
//   slave   the deserializer
interface serial_to_parallel_if #(
    parameter int width = 8
);
    logic             serial_valid;
    logic             serial_data;
    logic             parallel_ready;
    logic             parallel_valid;
    logic [width-1:0] parallel_data;
    logic             busy;
    logic             overrun;

    modport master (
        output serial_valid,
        output serial_data,
        output parallel_ready,
        input  parallel_valid,
        input  parallel_data,
        input  busy,
        input  overrun
    );

    modport slave (
        input  serial_valid,
        input  serial_data,
        input  parallel_ready,
        output parallel_valid,
        output parallel_data,
        output busy,
        output overrun
    );
endinterface

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - LSB-first serial-to-parallel converter with one-word output slot
//
// Ports:
//   clk   single clock, all state changes on its rising edge
//   rst   asynchronous, active-low reset
//   bus   serial_to_parallel_if.slave: serial bit input (no backpressure),
//         parallel word output with valid/ready, busy and overrun status
// Parameter:
//   width  bits per parallel word (>= 2)
module serial_to_parallel #(
    parameter int width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_to_parallel_if.slave   bus
);
    localparam int cnt_w = $clog2(width);
    localparam logic [cnt_w-1:0] last_bit = cnt_w'(width - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t            state;
    slot_t            state_next;
    logic [cnt_w-1:0] cnt;
    logic [width-1:0] shreg;
    logic [width-1:0] word;
    logic [width-1:0] data_q;
    logic             busy_q;
    logic             overrun_q;
    logic             complete;
    logic             handshake;
    logic             load;
    logic             drop;

    // New bits enter at the MSB and move down, so after width samples the
    // first bit sits at position 0. The word is taken including the bit
    // being sampled this cycle.
    always_comb begin
        word      = {bus.serial_data, shreg[width-1:1]};
        complete  = bus.serial_valid && (cnt == last_bit);
        handshake = (state == FULL) && bus.parallel_ready;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (complete) begin
                    state_next = FULL;
                    load       = 1'b1;
                end
            end
            FULL: begin
                if (complete) begin
                    // Slot stays full either way: replaced if consumed, kept otherwise.
                    if (handshake) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (handshake) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            shreg     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.serial_valid) begin
                shreg  <= word;
                cnt    <= complete ? '0 : cnt + 1'b1;
                // Counter is nonzero after any non-completing sample.
                busy_q <= !complete;
            end
            if (load) begin
                data_q <= word;
            end
            overrun_q <= drop;
        end
    end

    assign bus.parallel_valid = (state == FULL);
    assign bus.parallel_data  = data_q;
    assign bus.busy           = busy_q;
    assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - self-checking bench for serial_to_parallel
module tb_serial_to_parallel;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   run_cmp  = 0;

    serial_to_parallel_if #(.width(W)) bus ();

    serial_to_parallel #(.width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted bits collect in a queue; a full queue becomes
    // a word with bit i = i-th accepted bit. The output slot is a flag plus value.
    bit       m_bits[$];
    logic     m_full    = 1'b0;
    logic [W-1:0] m_data = '0;
    logic     m_overrun = 1'b0;
    logic [W-1:0] m_word;
    logic     m_hs;
    logic     m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_bits.delete();
            m_full    = 1'b0;
            m_data    = '0;
            m_overrun = 1'b0;
        end else begin
            m_hs      = m_full && bus.parallel_ready;
            m_done    = 1'b0;
            m_overrun = 1'b0;
            if (bus.serial_valid) begin
                m_bits.push_back(bus.serial_data);
                if (m_bits.size() == W) begin
                    m_word = '0;
                    for (int i = 0; i < W; i++) m_word[i] = m_bits[i];
                    m_bits.delete();
                    m_done = 1'b1;
                end
            end
            if (m_done) begin
                if (!m_full || m_hs) begin
                    m_data = m_word;
                    m_full = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (m_hs) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("valid", bus.parallel_valid, m_full);
            chk("data", bus.parallel_data, m_data);
            chk("busy", bus.busy, m_bits.size() != 0);
            chk("overrun", bus.overrun, m_overrun);
        end
    end

    task automatic step(input logic sv, input logic sd, input logic rdy);
        @(negedge clk);
        bus.serial_valid   = sv;
        bus.serial_data    = sd;
        bus.parallel_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input logic rdy);
        for (int i = 0; i < W; i++) step(1'b1, w[i], rdy);
    endtask

    logic [W-1:0] pat;

    initial begin
        rst                = 1'b0;
        bus.serial_valid   = 1'b0;
        bus.serial_data    = 1'b0;
        bus.parallel_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", bus.parallel_valid, 0);
        chk("reset_data", bus.parallel_data, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_overrun", bus.overrun, 0);
        run_cmp = 1;
        @(negedge clk);
        rst = 1'b1;

        // 0xA5 with busy tracked bit by bit
        pat = 8'hA5;
        for (int i = 0; i < W; i++) begin
            step(1'b1, pat[i], 1'b1);
            chk("a5_busy", bus.busy, (i < W - 1) ? 1 : 0);
        end
        chk("a5_valid", bus.parallel_valid, 1);
        chk("a5_data", bus.parallel_data, 8'hA5);
        step(1'b0, 1'b0, 1'b1);
        chk("a5_valid_drop", bus.parallel_valid, 0);

        // 0x3C with a two-cycle gap between bits 3 and 4
        pat = 8'h3C;
        for (int i = 0; i < W; i++) begin
            if (i == 4) begin
                repeat (2) begin
                    step(1'b0, 1'b1, 1'b1);
                    chk("gap_busy", bus.busy, 1);
                end
            end
            step(1'b1, pat[i], 1'b1);
        end
        chk("3c_data", bus.parallel_data, 8'h3C);
        step(1'b0, 1'b0, 1'b1);

        // Overrun: 0x11 held, 0x22 dropped
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        chk("ovr_pulse", bus.overrun, 1);
        chk("ovr_data", bus.parallel_data, 8'h11);
        chk("ovr_valid", bus.parallel_valid, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("ovr_pulse_end", bus.overrun, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("ovr_drain", bus.parallel_valid, 0);
        chk("ovr_retain", bus.parallel_data, 8'h11);

        // Handshake coinciding with completion
        send(8'h11, 1'b0);
        pat = 8'h22;
        for (int i = 0; i < W; i++) step(1'b1, pat[i], (i == W - 1));
        chk("coin_valid", bus.parallel_valid, 1);
        chk("coin_data", bus.parallel_data, 8'h22);
        chk("coin_overrun", bus.overrun, 0);
        step(1'b0, 1'b0, 1'b1);

        // Reset mid-word while a word is also held
        send(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", bus.parallel_valid, 0);
        chk("rst_data", bus.parallel_data, 0);
        chk("rst_busy", bus.busy, 0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_ignore", bus.busy, 0);
        rst = 1'b1;
        send(8'hFF, 1'b1);
        chk("ff_data", bus.parallel_data, 8'hFF);
        step(1'b0, 1'b0, 1'b1);

        // Back-to-back 0x01, 0x80
        for (int j = 0; j < 2 * W; j++) begin
            pat = (j < W) ? 8'h01 : 8'h80;
            step(1'b1, pat[j % W], 1'b1);
            if (j == W - 1) begin
                chk("b2b_first_valid", bus.parallel_valid, 1);
                chk("b2b_first", bus.parallel_data, 8'h01);
            end
            if (j == W) chk("b2b_gap", bus.parallel_valid, 0);
            if (j == 2 * W - 1) begin
                chk("b2b_second_valid", bus.parallel_valid, 1);
                chk("b2b_second", bus.parallel_data, 8'h80);
            end
        end

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                step(1'($urandom), 1'($urandom), 1'($urandom));
                rst = 1'b1;
            end else begin
                step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) < 4);
            end
        end

        step(1'b0, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter: width, default 8, number of bits per parallel word; legal range width >= 2.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 serial_valid  input  1  serial_data carries a valid bit this cycle.
REQ-005 serial_data  input  1  serial bit, LSB of the word first.
REQ-006 parallel_ready  input  1  consumer accepts parallel_data this cycle.
REQ-007 parallel_valid  output  1  parallel_data holds a complete, unconsumed word.
REQ-008 parallel_data  output  width  assembled word; bit i = i-th accepted serial bit.
REQ-009 busy  output  1  partial word in progress (1..width-1 bits collected).
REQ-010 overrun  output  1  one-cycle pulse: completed word dropped because the output slot was full.

Function
REQ-011 Serial side: no backpressure; every cycle with serial_valid=1 samples exactly one bit.
REQ-012 Bits: first accepted bit -> position 0, k-th accepted bit -> position k-1; shift register plus bit counter of $clog2(width) bits.
REQ-013 Gaps: serial_valid=0 cycles between bits allowed; counter and partial word hold unchanged.
REQ-014 busy: registered; =1 whenever bit counter != 0; =0 while idle or when the word completes.
REQ-015 Completion: the cycle sampling the width-th bit completes the word; counter wraps to 0 in that same edge.
REQ-016 Latency: completed word appears on parallel_data with parallel_valid=1 on the cycle after the last bit is sampled.
REQ-017 Output slot: single-entry holding register; parallel_valid=1 and parallel_data stable until handshake (parallel_valid && parallel_ready) at a clock edge.
REQ-018 Handshake without new word: parallel_valid -> 0 next cycle; parallel_data retains last value.
REQ-019 Slot states: EMPTY (parallel_valid=0), FULL (parallel_valid=1); EMPTY->FULL on completion; FULL->EMPTY on handshake with no completion; FULL->FULL on completion coinciding with handshake (new word loaded, parallel_valid stays 1).
REQ-020 Overrun: completion while FULL and no handshake in that cycle -> new word discarded, held word unchanged, overrun=1 for exactly the next cycle.
REQ-021 Overrun does not stall the serial side: next accepted bit starts a fresh word at position 0.
REQ-022 Back-to-back words (serial_valid=1 continuously) supported with zero idle cycles between words.
REQ-023 parallel_ready ignored while parallel_valid=0.

Reset
REQ-024 rst=0 asynchronously forces: parallel_valid=0, parallel_data=0, busy=0, overrun=0, bit counter=0, shift register=0.
REQ-025 Reset mid-word discards the partial word; the first bit accepted after rst=1 goes to position 0.
REQ-026 Reset while FULL discards the held word; no overrun pulse generated by reset.
REQ-027 While rst=0, serial_valid and parallel_ready are ignored.

Verification (width=8)
REQ-028 0xA5 LSB-first, 8 consecutive serial_valid cycles, parallel_ready=1 -> next cycle parallel_valid=1, parallel_data=0xA5 for one cycle; busy=1 from bit 1 through bit 7.
REQ-029 0x3C with serial_valid=0 for 2 cycles between bits 3 and 4 -> parallel_data=0x3C one cycle after 8th bit; busy held 1 during gap.
REQ-030 parallel_ready=0; send 0x11 then 0x22 -> parallel_data=0x11 held valid; overrun=1 for one cycle after 0x22 completes; data still 0x11; then ready=1 -> valid drops next cycle.
REQ-031 Holding 0x11, parallel_ready=1 exactly in the cycle the last bit of 0x22 is sampled -> 0x11 consumed, next cycle parallel_valid=1, parallel_data=0x22, overrun=0.
REQ-032 5 bits of a word then rst=0 for 2 cycles -> all outputs 0 immediately; then 0xFF sent -> parallel_data=0xFF, no residual bits.
REQ-033 0x01 then 0x80 on 16 continuous serial_valid cycles, ready=1 -> two parallel_valid pulses exactly 8 cycles apart with 0x01 then 0x80.
